spi_slave_fsm: RTL and testbench

//  Transaction sequencer for the SPI slave. Consumes the conditioned chip-select and the
//  one-cycle SCLK edge pulses from the input conditioners. Drives the control strobes for
//  the shift register, address latch, data memory and MISO tri-state buffer.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_bit_counter.sv | 24 ++
 rtl/spi_slave_fsm.sv | 122 ++++++++++++
 tb/tb_spi_slave_fsm.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and defaults for the SPI slave sequencer
package spi_pkg;

  localparam int DEF_ADDR_BITS = 7;
  localparam int DEF_DATA_BITS = 8;
  localparam logic RW_READ = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    GET_HDR,
    DECODE,
    RD_LOAD,
    RD_SHIFT,
    WR_SHIFT,
    WR_COMMIT,
    DONE
  } spi_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// rtl/spi_bit_counter.sv - saturating SCLK sample-edge counter with synchronous clear
module spi_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/spi_slave_fsm.sv
// rtl/spi_slave_fsm.sv - SPI slave transaction sequencer (header, decode, read/write data phase)
// Optional SPI_FSM_ABORT_FLAG_EN adds the sticky abort_err output.
module spi_slave_fsm
  import spi_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input  logic clk,
  input  logic reset,
  input  logic cs_n,
  input  logic sclk_posedge,
  input  logic sclk_negedge,
  input  logic rw_bit,
  output logic sr_load,
  output logic addr_we,
  output logic dm_we,
  output logic miso_oe,
  output logic busy
`ifdef SPI_FSM_ABORT_FLAG_EN
  ,
  output logic abort_err
`endif
);

  localparam int HDR_BITS = ADDR_BITS + 1;
  localparam int CW = $clog2(max2(HDR_BITS, DATA_BITS) + 1);
  localparam logic [CW-1:0] HDR_LAST  = CW'(HDR_BITS - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);

  spi_state_t    state, state_nx;
  logic [CW-1:0] cnt;
  logic          cnt_inc;
  logic          cnt_clr;
  logic          cs_q;
  logic          cs_fall;

  // cs_q resets low so a chip select already asserted at reset release does not start a frame
  assign cs_fall = cs_q & ~cs_n;
  assign cnt_clr = (state_nx != state);

  spi_bit_counter #(.WIDTH(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clr),
    .inc   (cnt_inc),
    .count (cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cs_q  <= 1'b0;
    end else begin
      state <= state_nx;
      cs_q  <= cs_n;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_inc  = 1'b0;
    case (state)
      IDLE:      if (cs_fall) state_nx = GET_HDR;
      GET_HDR: begin
        cnt_inc = sclk_posedge;
        if (sclk_posedge && (cnt == HDR_LAST)) state_nx = DECODE;
      end
      DECODE:    state_nx = (rw_bit == RW_READ) ? RD_LOAD : WR_SHIFT;
      RD_LOAD:   state_nx = RD_SHIFT;
      RD_SHIFT: begin
        cnt_inc = sclk_posedge;
        if (sclk_posedge && (cnt == DATA_LAST)) state_nx = DONE;
      end
      WR_SHIFT: begin
        cnt_inc = sclk_posedge;
        if (sclk_posedge && (cnt == DATA_LAST)) state_nx = WR_COMMIT;
      end
      WR_COMMIT: state_nx = DONE;
      DONE:      state_nx = DONE;
      default:   state_nx = IDLE;
    endcase
    // Deselect overrides any edge arriving in the same cycle
    if ((state != IDLE) && cs_n) begin
      state_nx = IDLE;
      cnt_inc  = 1'b0;
    end
  end

  // Outputs are decoded from the next state and registered, so they line up with the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_we <= 1'b0;
      sr_load <= 1'b0;
      dm_we   <= 1'b0;
      miso_oe <= 1'b0;
      busy    <= 1'b0;
    end else begin
      addr_we <= (state_nx == DECODE);
      sr_load <= (state_nx == RD_LOAD);
      dm_we   <= (state_nx == WR_COMMIT);
      miso_oe <= (state_nx == RD_SHIFT);
      busy    <= (state_nx != IDLE);
    end
  end

`ifdef SPI_FSM_ABORT_FLAG_EN
  logic abort_set;
  assign abort_set = cs_n && (state != IDLE) && (state != DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      abort_err <= 1'b0;
    end else if (abort_set) begin
      abort_err <= 1'b1;
    end else if (cs_fall) begin
      abort_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_fsm.sv
// tb/tb_spi_slave_fsm.sv - directed vector bench for spi_slave_fsm (honours SPI_FSM_ABORT_FLAG_EN)
module tb_spi_slave_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cs_n = 1'b1;
  logic sclk_posedge = 1'b0;
  logic sclk_negedge = 1'b0;
  logic rw_bit = 1'b0;
  logic sr_load, addr_we, dm_we, miso_oe, busy;
`ifdef SPI_FSM_ABORT_FLAG_EN
  logic abort_err;
`endif

  spi_slave_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .cs_n         (cs_n),
    .sclk_posedge (sclk_posedge),
    .sclk_negedge (sclk_negedge),
    .rw_bit       (rw_bit),
    .sr_load      (sr_load),
    .addr_we      (addr_we),
    .dm_we        (dm_we),
    .miso_oe      (miso_oe),
    .busy         (busy)
`ifdef SPI_FSM_ABORT_FLAG_EN
    ,
    .abort_err    (abort_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cs;
    logic       pe;
    logic       ne;
    logic       rw;
    logic [4:0] exp;
    string      name;
  } vec_t;

  vec_t vq[$];

  int total = 0;
  int bad = 0;
  int n_addr, n_sr, n_dm, n_miso, miso_pe, pe_cnt, cyc;
  int addr_cyc, sr_cyc, addr_pe, dm_pe;
  int addr_lat, dm_lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clear_stats();
    n_addr = 0; n_sr = 0; n_dm = 0; n_miso = 0; miso_pe = 0; pe_cnt = 0; cyc = 0;
    addr_cyc = -1; sr_cyc = -1; addr_pe = -1; dm_pe = -1; addr_lat = 0; dm_lat = 0;
  endtask

  task automatic clk1();
    logic pe_prev;
    pe_prev = sclk_posedge;
    if (sclk_posedge) pe_cnt++;
    if (sclk_posedge && miso_oe) miso_pe++;
    @(posedge clk);
    #1;
    cyc++;
    if (addr_we) begin n_addr++; addr_cyc = cyc; addr_pe = pe_cnt; addr_lat = int'(pe_prev); end
    if (sr_load) begin n_sr++; sr_cyc = cyc; end
    if (dm_we) begin n_dm++; dm_pe = pe_cnt; dm_lat = int'(pe_prev); end
    if (miso_oe) n_miso++;
  endtask

  task automatic sbit(input logic b);
    rw_bit = b;
    sclk_posedge = 1'b1;
    clk1();
    sclk_posedge = 1'b0;
    clk1();
    sclk_negedge = 1'b1;
    clk1();
    sclk_negedge = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sbit(v[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1; cs_n = 1'b1; sclk_posedge = 1'b0; sclk_negedge = 1'b0; rw_bit = 1'b0;
    clk1(); clk1();
    reset = 1'b0;
    clk1(); clk1();
    clear_stats();
  endtask

  task automatic add(input logic cs, input logic pe, input logic ne, input logic rw,
                     input logic [4:0] exp, input string name);
    vec_t v;
    v.cs = cs; v.pe = pe; v.ne = ne; v.rw = rw; v.exp = exp; v.name = name;
    vq.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // exp = {busy, addr_we, sr_load, dm_we, miso_oe}; read frame with pe/ne every clk
    add(1, 1, 0, 0, 5'b00000, "idle_edge");
    add(0, 0, 0, 0, 5'b10000, "cs_fall");
    for (int i = 0; i < 7; i++) add(0, 1, 0, 0, 5'b10000, "hdr_bit");
    add(0, 1, 0, 1, 5'b11000, "hdr_last");
    add(0, 0, 0, 1, 5'b10100, "rd_load");
    add(0, 0, 0, 1, 5'b10001, "rd_shift_entry");
    for (int i = 0; i < 7; i++) add(0, 1, 1, 0, 5'b10001, "data_pe_ne");
    add(0, 1, 1, 0, 5'b10000, "data_last");
    add(0, 1, 0, 0, 5'b10000, "done_edge");
    add(1, 0, 0, 0, 5'b00000, "cs_rise");

    clear_stats();
    reset = 1'b1;
    #2;
    chk("reset_outputs", {busy, addr_we, sr_load, dm_we, miso_oe}, 5'b0);
`ifdef SPI_FSM_ABORT_FLAG_EN
    chk("reset_abort_err", abort_err, 1'b0);
`endif
    do_reset();

    foreach (vq[i]) begin
      cs_n = vq[i].cs; sclk_posedge = vq[i].pe; sclk_negedge = vq[i].ne; rw_bit = vq[i].rw;
      clk1();
      chk(vq[i].name, {busy, addr_we, sr_load, dm_we, miso_oe}, vq[i].exp);
    end
    sclk_posedge = 1'b0; sclk_negedge = 1'b0;

    // write 7'h2A + W, data 8'hC3
    do_reset();
    cs_n = 1'b0; clk1();
    chk("wr_busy", busy, 1'b1);
    send_bits(32'h54, 8);
    chk("wr_addr_cnt", n_addr, 1);
    chk("wr_addr_pe", addr_pe, 8);
    chk("wr_addr_lat", addr_lat, 1);
    send_bits(32'hC3, 8);
    chk("wr_dm_cnt", n_dm, 1);
    chk("wr_dm_pe", dm_pe, 16);
    chk("wr_dm_lat", dm_lat, 1);
    chk("wr_no_rd", n_sr + n_miso, 0);
    chk("wr_done_busy", busy, 1'b1);
    cs_n = 1'b1; clk1();
    chk("wr_idle", busy, 1'b0);

    // read 7'h15 + R
    do_reset();
    cs_n = 1'b0; clk1();
    send_bits(32'h2B, 8);
    chk("rd_addr_cnt", n_addr, 1);
    chk("rd_sr_after_addr", sr_cyc - addr_cyc, 1);
    chk("rd_sr_cnt", n_sr, 1);
    send_bits(32'h00, 8);
    chk("rd_miso_pe", miso_pe, 8);
    chk("rd_done_miso", miso_oe, 1'b0);
    chk("rd_no_dm", n_dm, 0);
    chk("rd_done_busy", busy, 1'b1);
    cs_n = 1'b1; clk1();

    // abort after 4 header bits
    do_reset();
    cs_n = 1'b0; clk1();
    send_bits(32'h5, 4);
    cs_n = 1'b1; clk1();
    chk("abort_busy", busy, 1'b0);
    chk("abort_strobes", n_addr + n_sr + n_dm + n_miso, 0);
`ifdef SPI_FSM_ABORT_FLAG_EN
    chk("abort_flag", abort_err, 1'b1);
    clk1();
    chk("abort_sticky", abort_err, 1'b1);
`else
    clk1();
`endif
    cs_n = 1'b0; clk1();
    chk("abort_restart", busy, 1'b1);
`ifdef SPI_FSM_ABORT_FLAG_EN
    chk("abort_cleared", abort_err, 1'b0);
`endif

    // overrun: 20 posedges in one write frame
    do_reset();
    cs_n = 1'b0; clk1();
    send_bits(32'h54A5F, 20);
    chk("ovr_addr", n_addr, 1);
    chk("ovr_dm", n_dm, 1);
    chk("ovr_busy", busy, 1'b1);
    cs_n = 1'b1; clk1();
    chk("ovr_idle", busy, 1'b0);

    // async reset mid read data
    do_reset();
    cs_n = 1'b0; clk1();
    send_bits(32'h2B, 8);
    send_bits(32'h5, 3);
    chk("rst_pre_miso", miso_oe, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async", {busy, addr_we, sr_load, dm_we, miso_oe}, 5'b0);
    clk1();
    reset = 1'b0;
    clk1();
    send_bits(32'h7, 3);
    chk("rst_no_resume", busy, 1'b0);
    cs_n = 1'b1; clk1();
    cs_n = 1'b0; clk1();
    chk("rst_fresh_cs", busy, 1'b1);

    // cs_n rises with the 16th write posedge
    do_reset();
    cs_n = 1'b0; clk1();
    send_bits(32'h54, 8);
    send_bits(32'h7F, 7);
    cs_n = 1'b1; sclk_posedge = 1'b1; clk1();
    sclk_posedge = 1'b0;
    chk("sim_dm", n_dm, 0);
    chk("sim_idle", busy, 1'b0);
`ifdef SPI_FSM_ABORT_FLAG_EN
    chk("sim_abort", abort_err, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
